reg_read_mux: RTL and testbench
===============================

Name: reg_read_mux

Overview:
Parametrised multi-port register file with registered read multiplexing, for the processor datapath. It holds NUM_REGS words and serves NUM_RD independent read ports with one-cycle latency. One write port feeds the array and a write-to-read bypass. It generalises the single-port, fixed-width register read mux with an enable/valid handshake, an optional hardwired zero register, out-of-range detection and reset.

Parameters:
DATA_W, 32, width of each register and each read/write data bus
ADDR_W, 5, width of each register address
NUM_REGS, 32, number of implemented registers; must satisfy 2 <= NUM_REGS <= 2**ADDR_W
NUM_RD, 2, number of read ports; must satisfy 1..4
ZERO_REG, 1, when 1, register 0 reads as 0 and writes to it are discarded
BYPASS, 1, when 1, a same-cycle write to the addressed register is forwarded to the read result

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
rd_en  input  NUM_RD  per-port read request; bit p belongs to port p
rd_adr  input  NUM_RD*ADDR_W  per-port address; port p is bits [p*ADDR_W +: ADDR_W]
wr_en  input  1  write strobe
wr_adr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_data  output  NUM_RD*DATA_W  per-port registered read data; port p is bits [p*DATA_W +: DATA_W]
rd_valid  output  NUM_RD  per-port: rd_data captured on the previous edge
rd_err  output  NUM_RD  per-port: the last accepted read addressed a location >= NUM_REGS

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - all NUM_REGS registers clear to 0
  - rd_data, rd_valid and rd_err clear to 0
  - reset asserted mid-operation drops any in-flight read; no rd_valid pulse follows
  - the first edge after rst deasserts behaves as a normal cycle
- Write (on posedge, when wr_en=1):
  - wr_adr < NUM_REGS: reg[wr_adr] <= wr_data
  - wr_adr >= NUM_REGS: write ignored, no flag
  - ZERO_REG=1 and wr_adr=0: write ignored
- Read, port p (on posedge, when rd_en[p]=1), captures into rd_data[p]:
  - 0, if rd_adr[p] >= NUM_REGS; rd_err[p] <= 1
  - 0, if ZERO_REG=1 and rd_adr[p]=0
  - wr_data, if BYPASS=1, wr_en=1 and wr_adr=rd_adr[p], and the write is not discarded by the zero-register or range rules
  - otherwise the pre-edge reg[rd_adr[p]]; with BYPASS=0 a same-cycle write is not visible until the next read
  - rd_valid[p] <= 1; rd_err[p] <= 1 only in the out-of-range case, else 0
- Latency: exactly one clock from rd_en sample to rd_data/rd_valid.
- rd_en[p]=0 on an edge: rd_data[p] and rd_err[p] hold their values; rd_valid[p] <= 0. rd_valid is a single-cycle pulse per accepted read.
- Ports are fully independent:
  - any number of ports may read the same address in the same cycle, all with identical results
  - no arbitration and no stalls
- Addresses are compared at full ADDR_W width with no truncation or wrap-around, so rd_adr = NUM_REGS is out of range.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5; next cycle rd_en[0]=1, rd_adr0=5 -> one cycle later rd_data0=0xDEADBEEF, rd_valid0=1, rd_err0=0.
2. Same cycle: wr_en=1, wr_adr=7, wr_data=0x12345678 and rd_en[1]=1, rd_adr1=7 -> BYPASS=1: rd_data1=0x12345678. BYPASS=0: rd_data1=old r7 (0 after reset); a following read returns 0x12345678.
3. ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 on both ports, including same-cycle bypass attempt -> rd_data0=rd_data1=0, rd_valid=2'b11.
4. NUM_REGS=16: read address 16 on port 0 and address 15 (holding 0xA5A5A5A5) on port 1 -> rd_data0=0, rd_err0=1; rd_data1=0xA5A5A5A5, rd_err1=0.
5. Read r3=0x55 on port 0, then drop rd_en[0] for 3 cycles while writing r3=0x66 -> rd_data0 stays 0x55, rd_valid0 is a 1-cycle pulse then 0.
6. Assert rst between clock edges during an active read of r9=0x99 -> rd_data, rd_valid and rd_err go 0 immediately, with no valid pulse after release; a subsequent read of r9 returns 0.

Source files
------------

// File: rtl/reg_read_mux.sv
// Multi-port register file with one write port and NUM_RD registered read ports.
// Each read port returns data one clock after its request, with optional bypass and zero register.
module reg_read_mux #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_adr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_err
);

    // Array index width; the range check below guarantees the upper address bits are zero.
    localparam int              IDX_W     = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    // Full-width comparison, so addresses at or above NUM_REGS never alias a real register.
    function automatic logic in_range(input logic [ADDR_W-1:0] adr);
        return {1'b0, adr} < REG_LIMIT;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] adr);
        return ZERO_REG && (adr == '0);
    endfunction

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_accept;
    logic [IDX_W-1:0]  wr_idx;

    assign wr_accept = wr_en && in_range(wr_adr) && !is_zero_reg(wr_adr);
    assign wr_idx    = wr_adr[IDX_W-1:0];

    // NOTE: the storage array is reset because the register file must read as zero after reset;
    // this costs a reset net on every flop, which is accepted here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_accept) begin
            // NOTE: non-blocking assignment so every read below sees the pre-edge contents.
            regs[wr_idx] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] adr;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data_nxt;
        logic              err_nxt;
        logic [DATA_W-1:0] data_q;
        logic              err_q;
        logic              valid_q;

        assign adr = rd_adr[p*ADDR_W +: ADDR_W];
        assign idx = adr[IDX_W-1:0];

        always_comb begin
            // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
            data_nxt = '0;
            err_nxt  = 1'b0;
            if (!in_range(adr)) begin
                err_nxt = 1'b1;
            end else if (is_zero_reg(adr)) begin
                data_nxt = '0;
            end else if (BYPASS && wr_accept && (wr_adr == adr)) begin
                data_nxt = wr_data;
            end else begin
                data_nxt = regs[idx];
            end
        end

        // Data and error hold between reads; valid is a one-cycle pulse per accepted read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                err_q   <= 1'b0;
                valid_q <= 1'b0;
            end else if (rd_en[p]) begin
                data_q  <= data_nxt;
                err_q   <= err_nxt;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_q;
        assign rd_err[p]                   = err_q;
        assign rd_valid[p]                 = valid_q;
    end

endmodule

// File: tb/tb_reg_read_mux.sv
// Bench for reg_read_mux: two configurations driven by shared stimulus, checked against
// a queue-based scoreboard plus directed constant checks for each scenario.
module tb_reg_read_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_adr;
    logic        wr_en;
    logic [4:0]  wr_adr;
    logic [31:0] wr_data;
    logic [63:0] a_data,  b_data;
    logic [1:0]  a_valid, b_valid, a_err, b_err;

    always #5 clk = ~clk;

    // Config A: 16 registers, zero register, bypass on.
    reg_read_mux #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .NUM_RD(2),
                   .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_adr(rd_adr), .wr_en(wr_en),
        .wr_adr(wr_adr), .wr_data(wr_data), .rd_data(a_data), .rd_valid(a_valid), .rd_err(a_err));

    // Config B: 32 registers, no zero register, bypass off.
    reg_read_mux #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2),
                   .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_adr(rd_adr), .wr_en(wr_en),
        .wr_adr(wr_adr), .wr_data(wr_data), .rd_data(b_data), .rd_valid(b_valid), .rd_err(b_err));

    typedef struct {
        logic [63:0] data;
        logic [1:0]  valid;
        logic [1:0]  err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int cfg_nregs [2] = '{16, 32};
    bit cfg_zero  [2] = '{1'b1, 1'b0};
    bit cfg_byp   [2] = '{1'b1, 1'b0};

    logic [31:0] mem       [2][32];
    logic [31:0] hold_data [2][2];
    logic        hold_err  [2][2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) mem[d][i] = '0;
            for (int p = 0; p < 2; p++) begin
                hold_data[d][p] = '0;
                hold_err[d][p]  = 1'b0;
            end
        end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
        wr_en   = we;
        wr_adr  = wa;
        wr_data = wd;
        rd_en   = re;
        rd_adr  = {a1, a0};
    endtask

    // Compute what config d must show after the coming edge, then commit the write.
    task automatic predict(input int d);
        exp_t        e;
        logic [4:0]  adr;
        bit          wr_ok;
        e = '{data: '0, valid: '0, err: '0};
        wr_ok = wr_en && (int'(wr_adr) < cfg_nregs[d]) && !(cfg_zero[d] && wr_adr == 5'd0);
        for (int p = 0; p < 2; p++) begin
            adr = rd_adr[p*5 +: 5];
            if (rd_en[p]) begin
                if (int'(adr) >= cfg_nregs[d]) begin
                    hold_data[d][p] = '0;
                    hold_err[d][p]  = 1'b1;
                end else begin
                    hold_err[d][p] = 1'b0;
                    if (cfg_zero[d] && adr == 5'd0)                 hold_data[d][p] = '0;
                    else if (cfg_byp[d] && wr_ok && wr_adr == adr)  hold_data[d][p] = wr_data;
                    else                                            hold_data[d][p] = mem[d][adr];
                end
            end
            e.data[p*32 +: 32] = hold_data[d][p];
            e.err[p]           = hold_err[d][p];
            e.valid[p]         = rd_en[p];
        end
        if (wr_ok) mem[d][wr_adr] = wr_data;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // Push expectations, advance one edge, pop and compare both configurations.
    task automatic step(input string tag);
        exp_t        e;
        logic [63:0] act_data;
        logic [1:0]  act_valid, act_err;
        predict(0);
        predict(1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ((d == 0 ? q_a.size() : q_b.size()) == 0) begin
                n_bad++;
                $display("FAIL %s cfg%0d: scoreboard empty, got 0 entries want 1", tag, d);
                continue;
            end
            e         = (d == 0) ? q_a.pop_front() : q_b.pop_front();
            act_data  = (d == 0) ? a_data  : b_data;
            act_valid = (d == 0) ? a_valid : b_valid;
            act_err   = (d == 0) ? a_err   : b_err;
            if (act_data !== e.data) begin
                n_bad++;
                $display("FAIL %s cfg%0d rd_data: got %h want %h", tag, d, act_data, e.data);
            end
            n_cmp++;
            if (act_valid !== e.valid) begin
                n_bad++;
                $display("FAIL %s cfg%0d rd_valid: got %b want %b", tag, d, act_valid, e.valid);
            end
            n_cmp++;
            if (act_err !== e.err) begin
                n_bad++;
                $display("FAIL %s cfg%0d rd_err: got %b want %b", tag, d, act_err, e.err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 2'b00, '0, '0);
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if ({a_data, a_valid, a_err, b_data, b_valid, b_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got a=%h/%b/%b b=%h/%b/%b want all zero",
                     a_data, a_valid, a_err, b_data, b_valid, b_err);
        end
        rst = 1'b0;
        step("reset_idle");
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, '0, '0);
        step("wr_r5");
        drive(1'b0, '0, '0, 2'b01, 5'd5, '0);
        step("rd_r5");
        n_cmp++;
        if (a_data[31:0] !== 32'hDEADBEEF || a_valid[0] !== 1'b1 || a_err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_r5_direct: got %h/%b/%b want deadbeef/1/0", a_data[31:0], a_valid[0], a_err[0]);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'h12345678, 2'b10, '0, 5'd7);
        step("bypass_r7");
        n_cmp++;
        if (a_data[63:32] !== 32'h12345678 || b_data[63:32] !== 32'h0) begin
            n_bad++;
            $display("FAIL bypass_direct: got a=%h b=%h want a=12345678 b=00000000", a_data[63:32], b_data[63:32]);
        end
        drive(1'b0, '0, '0, 2'b10, '0, 5'd7);
        step("reread_r7");
        n_cmp++;
        if (b_data[63:32] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL nobypass_reread: got %h want 12345678", b_data[63:32]);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 2'b00, '0, '0);
        step("wr_r0");
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0);
        step("rd_r0_both");
        n_cmp++;
        if (a_data !== 64'h0 || a_valid !== 2'b11) begin
            n_bad++;
            $display("FAIL zero_reg_direct: got %h/%b want 0/11", a_data, a_valid);
        end
    endtask

    task automatic test_range();
        drive(1'b1, 5'd15, 32'hA5A5A5A5, 2'b00, '0, '0);
        step("wr_r15");
        drive(1'b1, 5'd16, 32'h0BAD0BAD, 2'b11, 5'd16, 5'd15);
        step("rd_16_15");
        n_cmp++;
        if (a_data !== {32'hA5A5A5A5, 32'h0} || a_err !== 2'b01) begin
            n_bad++;
            $display("FAIL range_direct: got %h/%b want a5a5a5a500000000/01", a_data, a_err);
        end
        drive(1'b0, '0, '0, 2'b11, 5'd31, 5'd16);
        step("rd_31_16");
    endtask

    task automatic test_hold();
        drive(1'b1, 5'd3, 32'h55, 2'b00, '0, '0);
        step("wr_r3");
        drive(1'b0, '0, '0, 2'b01, 5'd3, '0);
        step("rd_r3");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd3, 32'h66, 2'b00, 5'd3, '0);
            step("hold_r3");
            n_cmp++;
            if (a_data[31:0] !== 32'h55 || a_valid[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_direct: got %h/%b want 00000055/0", a_data[31:0], a_valid[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step("random");
        end
    endtask

    task automatic test_reset_midread();
        drive(1'b1, 5'd9, 32'h99, 2'b00, '0, '0);
        step("wr_r9");
        drive(1'b0, '0, '0, 2'b01, 5'd9, '0);
        step("rd_r9");
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_data, a_valid, a_err, b_data, b_valid, b_err} !== '0) begin
            n_bad++;
            $display("FAIL midread_reset_immediate: got a=%h/%b/%b b=%h/%b/%b want all zero",
                     a_data, a_valid, a_err, b_data, b_valid, b_err);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({a_data, a_valid, a_err, b_data, b_valid, b_err} !== '0) begin
            n_bad++;
            $display("FAIL midread_reset_held: got a=%h/%b b=%h/%b want all zero",
                     a_data, a_valid, b_data, b_valid);
        end
        rst = 1'b0;
        model_reset();
        drive(1'b0, '0, '0, 2'b00, '0, '0);
        step("post_reset_idle");
        drive(1'b0, '0, '0, 2'b01, 5'd9, '0);
        step("rd_r9_after_reset");
        n_cmp++;
        if (a_data[31:0] !== 32'h0 || a_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL r9_cleared: got %h/%b want 00000000/1", a_data[31:0], a_valid[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_range();
        test_hold();
        test_back_to_back();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
